// File: rtl/mux_arb_rr_pkg.sv
// Shared definitions for the N-channel arbitrated output mux.
// Defaults match the RISCV32 datapath width.
package mux_arb_rr_pkg;

    localparam int XLEN      = 32;
    localparam int DEF_WIDTH = XLEN;
    localparam int DEF_N_CH  = 4;

    localparam bit ARB_RR    = 1'b1;
    localparam bit ARB_FIXED = 1'b0;

    // A single channel still needs a one-bit index port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_arb_rr_arb_core.sv
// Combinational arbiter: rotate the request vector so the search starts at ptr,
// take the lowest set bit, then map the offset back to an absolute channel index.
module arb_rr_core #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            rr_en,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] idx
);
    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    logic [CH_W-1:0] start;
    logic [N_CH-1:0] rot;
    logic [CH_W:0]   offset;
    logic [CH_W:0]   sum;
    logic            found;

    always_comb begin
        start  = rr_en ? ptr : '0;
        rot    = N_CH'({req, req} >> start);
        found  = 1'b0;
        offset = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && rot[k]) begin
                found  = 1'b1;
                offset = k[CH_W:0];
            end
        end
        sum = {1'b0, start} + offset;
        if (sum >= N_CH_L) begin
            sum = sum - N_CH_L;
        end
        idx   = found ? sum[CH_W-1:0] : '0;
        grant = '0;
        for (int k = 0; k < N_CH; k++) begin
            grant[k] = found && (idx == k[CH_W-1:0]);
        end
    end

endmodule

// File: rtl/mux_arb_rr.sv
// N-to-1 handshake mux with built-in arbitration and one registered output stage.
// Fill and drain can happen in the same cycle, so a steady stream has no bubbles.
module mux_arb_rr
    import mux_arb_rr_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N_CH  = DEF_N_CH,
    parameter  bit RR_EN = ARB_RR,
    localparam int CH_W  = ch_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*WIDTH-1:0]  in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  grantIdx;
    logic             loadEn;
    logic             xfer;

    logic [WIDTH-1:0] outData_d,  outData_q;
    logic [CH_W-1:0]  outCh_d,    outCh_q;
    logic             outValid_d, outValid_q;
    logic [CH_W-1:0]  ptr_d,      ptr_q;

    arb_rr_core #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_core (
        .req   (in_valid),
        .ptr   (ptr_q),
        .rr_en (RR_EN),
        .grant (grant),
        .idx   (grantIdx)
    );

    assign loadEn   = !outValid_q || out_ready;
    assign in_ready = grant & {N_CH{loadEn}};
    assign xfer     = |in_ready;

    // Data and channel only change on a transfer; an empty load just drops valid.
    always_comb begin
        outData_d  = outData_q;
        outCh_d    = outCh_q;
        outValid_d = outValid_q;
        ptr_d      = ptr_q;
        if (loadEn) begin
            outValid_d = xfer;
            if (xfer) begin
                outData_d = in_data[int'(grantIdx)*WIDTH +: WIDTH];
                outCh_d   = grantIdx;
                if (RR_EN) begin
                    ptr_d = (grantIdx == LAST_CH) ? '0 : grantIdx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outData_q  <= '0;
            outCh_q    <= '0;
            outValid_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            outData_q  <= outData_d;
            outCh_q    <= outCh_d;
            outValid_q <= outValid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_data  = outData_q;
    assign out_ch    = outCh_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Self-checking bench: round-robin, fixed-priority and single-channel instances
// share one stimulus stream and are compared against a behavioural model.
module tb_mux_arb_rr;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] inData;
    logic [3:0]   inValid;
    logic         outReady;

    logic [3:0]  rrReady, fxReady;
    logic [31:0] rrData, fxData, oneData;
    logic        rrValid, fxValid, oneValid, oneReady;
    logic [1:0]  rrCh, fxCh;
    logic        oneCh;

    int total = 0;
    int bad   = 0;

    // Model state for instance 0 (round-robin), 1 (fixed), 2 (single channel)
    int          nCh[3]    = '{4, 4, 1};
    bit          rrMode[3] = '{1'b1, 1'b0, 1'b1};
    bit          mValid[3];
    logic [31:0] mData[3];
    int          mCh[3];
    int          mPtr[3];

    always #5 clk = ~clk;

    mux_arb_rr #(.WIDTH(32), .N_CH(4), .RR_EN(1'b1)) dutRr (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
        .in_ready(rrReady), .out_data(rrData), .out_valid(rrValid),
        .out_ready(outReady), .out_ch(rrCh)
    );

    mux_arb_rr #(.WIDTH(32), .N_CH(4), .RR_EN(1'b0)) dutFx (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
        .in_ready(fxReady), .out_data(fxData), .out_valid(fxValid),
        .out_ready(outReady), .out_ch(fxCh)
    );

    mux_arb_rr #(.WIDTH(32), .N_CH(1), .RR_EN(1'b1)) dutOne (
        .clk(clk), .rst(rst), .in_data(inData[31:0]), .in_valid(inValid[0:0]),
        .in_ready(oneReady), .out_data(oneData), .out_valid(oneValid),
        .out_ready(outReady), .out_ch(oneCh)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dutData(input int k);
        case (k)
            0:       return rrData;
            1:       return fxData;
            default: return oneData;
        endcase
    endfunction

    function automatic logic [31:0] dutValid(input int k);
        case (k)
            0:       return {31'b0, rrValid};
            1:       return {31'b0, fxValid};
            default: return {31'b0, oneValid};
        endcase
    endfunction

    function automatic logic [31:0] dutCh(input int k);
        case (k)
            0:       return {30'b0, rrCh};
            1:       return {30'b0, fxCh};
            default: return {31'b0, oneCh};
        endcase
    endfunction

    function automatic logic [31:0] dutReady(input int k);
        case (k)
            0:       return {28'b0, rrReady};
            1:       return {28'b0, fxReady};
            default: return {31'b0, oneReady};
        endcase
    endfunction

    // First requesting channel in circular order from the start point
    function automatic int winner(input int k);
        int start;
        start = rrMode[k] ? mPtr[k] : 0;
        for (int j = 0; j < nCh[k]; j++) begin
            int c;
            c = (start + j) % nCh[k];
            if (inValid[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mValid[k] = 1'b0;
            mData[k]  = '0;
            mCh[k]    = 0;
            mPtr[k]   = 0;
        end
    endtask

    task automatic modelClock();
        for (int k = 0; k < 3; k++) begin
            int w;
            w = winner(k);
            if (!mValid[k] || outReady) begin
                if (w >= 0) begin
                    mValid[k] = 1'b1;
                    mData[k]  = inData[w*32 +: 32];
                    mCh[k]    = w;
                    if (rrMode[k]) mPtr[k] = (w + 1) % nCh[k];
                end else begin
                    mValid[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic checkReadyAll();
        for (int k = 0; k < 3; k++) begin
            int w;
            logic [31:0] exp;
            w   = winner(k);
            exp = ((!mValid[k] || outReady) && w >= 0) ? (32'd1 << w) : 32'd0;
            checkOutput($sformatf("ready%0d", k), dutReady(k), exp);
        end
    endtask

    task automatic checkOutsAll();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("valid%0d", k), dutValid(k), {31'b0, mValid[k]});
            checkOutput($sformatf("data%0d", k), dutData(k), mData[k]);
            checkOutput($sformatf("ch%0d", k), dutCh(k), mCh[k]);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic r);
        inValid  = v;
        outReady = r;
    endtask

    task automatic randomData();
        for (int i = 0; i < 4; i++) inData[i*32 +: 32] = $urandom;
    endtask

    // Inputs are already driven at the negedge; check ready, clock, check outputs
    task automatic runCycle();
        #1 checkReadyAll();
        @(posedge clk);
        if (!rst) modelClock();
        @(negedge clk);
        checkOutsAll();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        modelReset();
        randomData();
        applyStimulus(4'($urandom_range(0, 15)), 1'b1);
        for (int i = 0; i < 3; i++) begin
            randomData();
            applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            runCycle();
        end
        checkOutput("rstValid", {31'b0, rrValid}, 32'd0);
        checkOutput("rstData", rrData, 32'd0);
        rst = 1'b0;

        applyStimulus(4'b1111, 1'b1);
        #1 checkOutput("firstGrant", {28'b0, rrReady}, 32'h1);

        // Single requester on ch2
        inData[64 +: 32] = 32'hFFFFAAAA;
        applyStimulus(4'b0100, 1'b1);
        runCycle();
        checkOutput("singleValid", {31'b0, rrValid}, 32'd1);
        checkOutput("singleData", rrData, 32'hFFFFAAAA);
        checkOutput("singleCh", {30'b0, rrCh}, 32'd2);
        applyStimulus(4'b1111, 1'b1);
        #1 checkOutput("ptrAfterCh2", {28'b0, rrReady}, 32'h8);
        runCycle();

        // Round-robin fairness with all channels requesting
        for (int i = 0; i < 4; i++) inData[i*32 +: 32] = 32'h6666AFAF + i;
        for (int j = 0; j < 6; j++) begin
            applyStimulus(4'b1111, 1'b1);
            runCycle();
            checkOutput("rrSeqCh", {30'b0, rrCh}, j % 4);
            checkOutput("rrSeqValid", {31'b0, rrValid}, 32'd1);
        end

        // Backpressure: load ch2 then stall three cycles
        inData[64 +: 32] = 32'hAFAF1010;
        applyStimulus(4'b1111, 1'b1);
        runCycle();
        checkOutput("bpLoad", rrData, 32'hAFAF1010);
        for (int j = 0; j < 3; j++) begin
            randomData();
            applyStimulus(4'b1111, 1'b0);
            #1 checkOutput("bpReady", {28'b0, rrReady}, 32'h0);
            runCycle();
            checkOutput("bpData", rrData, 32'hAFAF1010);
            checkOutput("bpCh", {30'b0, rrCh}, 32'd2);
        end
        applyStimulus(4'b1111, 1'b1);
        #1 checkOutput("bpResume", {28'b0, rrReady}, 32'h8);
        runCycle();

        // Fixed priority starves ch3 until ch1 drops
        for (int j = 0; j < 4; j++) begin
            randomData();
            applyStimulus(4'b1010, 1'b1);
            runCycle();
            checkOutput("fixCh1", {30'b0, fxCh}, 32'd1);
        end
        applyStimulus(4'b1000, 1'b1);
        runCycle();
        checkOutput("fixCh3", {30'b0, fxCh}, 32'd3);

        // Asynchronous reset between edges while a word is held
        applyStimulus(4'b1111, 1'b1);
        runCycle();
        checkOutput("preRstValid", {31'b0, rrValid}, 32'd1);
        #2 rst = 1'b1;
        modelReset();
        #1;
        checkOutput("asyncValid", {31'b0, rrValid}, 32'd0);
        checkOutput("asyncData", rrData, 32'd0);
        checkOutput("asyncCh", {30'b0, rrCh}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b1);
        #1 checkOutput("postRstGrant", {28'b0, rrReady}, 32'h1);
        runCycle();

        // Random traffic against the model
        for (int j = 0; j < 400; j++) begin
            randomData();
            applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            runCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
